// File: rtl/minmax_pkg.sv
// Shared types and sizing helpers for the min/max sort engine.
package minmax_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Width of the swap counter: enough to hold every possible exchange of a batch.
    function automatic int calc_scw(input int depth);
        return $clog2((depth * (depth - 1)) / 2 + 1);
    endfunction

    // Compare-exchange cycles in an even phase: pairs (0,1), (2,3), ...
    function automatic int even_cycles(input int depth);
        return depth / 2;
    endfunction

    // Compare-exchange cycles in an odd phase: pairs (1,2), (3,4), ...
    function automatic int odd_cycles(input int depth);
        return (depth - 1) / 2;
    endfunction

    // Total SORT length: DEPTH phases, alternating even/odd, starting even.
    function automatic int sort_cycles(input int depth);
        return ((depth + 1) / 2) * even_cycles(depth) + (depth / 2) * odd_cycles(depth);
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/minmax_cx.sv
// Combinational signed compare-exchange: larger value on Hi, ties keep A on Hi.
module minmax_cx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic signed [DATA_WIDTH-1:0] A,
    input  logic signed [DATA_WIDTH-1:0] B,
    output logic signed [DATA_WIDTH-1:0] Hi,
    output logic signed [DATA_WIDTH-1:0] Lo,
    output logic                         Swapped
);

    // Order the pair; strict compare so equal words are never exchanged.
    always_comb begin
        Swapped = (A < B);
        if (Swapped) begin
            Hi = B;
            Lo = A;
        end else begin
            Hi = A;
            Lo = B;
        end
    end

endmodule

// File: rtl/minmax_sort_engine.sv
// Batch sorter: loads DEPTH signed words, sorts them descending with one
// shared compare-exchange by odd-even transposition, then streams them out.
module minmax_sort_engine
    import minmax_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 8,
    localparam int SCW        = calc_scw(DEPTH)
) (
    input  logic                         Clk,
    input  logic                         nRst,
    input  logic                         InValid,
    output logic                         InReady,
    input  logic signed [DATA_WIDTH-1:0] InData,
    output logic                         OutValid,
    input  logic                         OutReady,
    output logic signed [DATA_WIDTH-1:0] OutData,
    output logic                         OutLast,
    input  logic                         Abort,
    output logic                         Busy,
    output logic [SCW-1:0]               SwapCount
);

    localparam int E_CYC = even_cycles(DEPTH);
    localparam int O_CYC = odd_cycles(DEPTH);
    localparam int S_CYC = sort_cycles(DEPTH);
    localparam int IW    = width_for(DEPTH);
    localparam int PHW   = width_for(DEPTH);
    localparam int PRW   = width_for(E_CYC);
    localparam int CW    = width_for(S_CYC);

    localparam logic [IW-1:0]  LAST_IDX  = IW'(DEPTH - 1);
    localparam logic [CW-1:0]  LAST_CYC  = CW'(S_CYC - 1);
    localparam logic [PRW-1:0] EVEN_LAST = PRW'(E_CYC - 1);
    // DEPTH=2 has no odd pairs; the sort ends before an odd phase is reached.
    localparam logic [PRW-1:0] ODD_LAST  = PRW'((O_CYC > 0) ? (O_CYC - 1) : 0);

    // Architectural state
    state_e                        r_state;
    logic signed [DATA_WIDTH-1:0]  r_buf [DEPTH];
    logic [IW-1:0]                 r_wr;
    logic [IW-1:0]                 r_rd;
    logic [PHW-1:0]                r_phase;
    logic [PRW-1:0]                r_pair;
    logic [CW-1:0]                 r_cyc;
    logic [SCW-1:0]                r_acc;
    logic [SCW-1:0]                r_swap_cnt;

    // Registered outputs
    logic                          r_in_ready;
    logic                          r_out_valid;
    logic                          r_out_last;
    logic signed [DATA_WIDTH-1:0]  r_out_data;
    logic                          r_busy;

    // Next-state values
    state_e                        w_state_next;
    logic signed [DATA_WIDTH-1:0]  w_buf_next [DEPTH];
    logic [IW-1:0]                 w_wr_next;
    logic [IW-1:0]                 w_rd_next;
    logic [PHW-1:0]                w_phase_next;
    logic [PRW-1:0]                w_pair_next;
    logic [CW-1:0]                 w_cyc_next;
    logic [SCW-1:0]                w_acc_next;
    logic [SCW-1:0]                w_swap_cnt_next;

    // Compare-exchange datapath
    logic [IW-1:0]                 w_lo_idx;
    logic [IW-1:0]                 w_hi_idx;
    logic signed [DATA_WIDTH-1:0]  w_cx_a;
    logic signed [DATA_WIDTH-1:0]  w_cx_b;
    logic signed [DATA_WIDTH-1:0]  w_cx_hi;
    logic signed [DATA_WIDTH-1:0]  w_cx_lo;
    logic                          w_cx_swapped;

    // Pair (i, i+1): i = 2*pair on even phases, 2*pair+1 on odd phases.
    assign w_lo_idx = IW'({r_pair, r_phase[0]});
    assign w_hi_idx = w_lo_idx + IW'(1);
    assign w_cx_a   = r_buf[w_lo_idx];
    assign w_cx_b   = r_buf[w_hi_idx];

    minmax_cx #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cx (
        .A       (w_cx_a),
        .B       (w_cx_b),
        .Hi      (w_cx_hi),
        .Lo      (w_cx_lo),
        .Swapped (w_cx_swapped)
    );

    // Next-state logic: load, one exchange per SORT cycle, drain; Abort wins over all.
    always_comb begin
        w_state_next    = r_state;
        w_buf_next      = r_buf;
        w_wr_next       = r_wr;
        w_rd_next       = r_rd;
        w_phase_next    = r_phase;
        w_pair_next     = r_pair;
        w_cyc_next      = r_cyc;
        w_acc_next      = r_acc;
        w_swap_cnt_next = r_swap_cnt;

        if (Abort) begin
            w_state_next    = LOAD;
            w_wr_next       = '0;
            w_rd_next       = '0;
            w_phase_next    = '0;
            w_pair_next     = '0;
            w_cyc_next      = '0;
            w_acc_next      = '0;
            w_swap_cnt_next = '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (InValid) begin
                        w_buf_next[r_wr] = InData;
                        if (r_wr == LAST_IDX) begin
                            w_state_next = SORT;
                            w_wr_next    = '0;
                            w_phase_next = '0;
                            w_pair_next  = '0;
                            w_cyc_next   = '0;
                            w_acc_next   = '0;
                        end else begin
                            w_wr_next = r_wr + IW'(1);
                        end
                    end else begin
                        w_wr_next = r_wr;
                    end
                end
                SORT: begin
                    w_buf_next[w_lo_idx] = w_cx_hi;
                    w_buf_next[w_hi_idx] = w_cx_lo;
                    w_acc_next           = r_acc + SCW'(w_cx_swapped);
                    if (r_cyc == LAST_CYC) begin
                        // Length is fixed, so the last cycle is known without data inspection.
                        w_state_next    = DRAIN;
                        w_swap_cnt_next = w_acc_next;
                        w_rd_next       = '0;
                        w_cyc_next      = '0;
                        w_phase_next    = '0;
                        w_pair_next     = '0;
                    end else begin
                        w_cyc_next = r_cyc + CW'(1);
                        if (r_pair == (r_phase[0] ? ODD_LAST : EVEN_LAST)) begin
                            w_pair_next  = '0;
                            w_phase_next = r_phase + PHW'(1);
                        end else begin
                            w_pair_next = r_pair + PRW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (OutReady) begin
                        if (r_rd == LAST_IDX) begin
                            w_rd_next    = '0;
                            w_state_next = LOAD;
                        end else begin
                            w_rd_next = r_rd + IW'(1);
                        end
                    end else begin
                        w_rd_next = r_rd;
                    end
                end
                default: begin
                    w_state_next = LOAD;
                    w_wr_next    = '0;
                    w_rd_next    = '0;
                end
            endcase
        end
    end

    // State, buffer and counter registers.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            r_state    <= LOAD;
            r_buf      <= '{default: '0};
            r_wr       <= '0;
            r_rd       <= '0;
            r_phase    <= '0;
            r_pair     <= '0;
            r_cyc      <= '0;
            r_acc      <= '0;
            r_swap_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_buf      <= w_buf_next;
            r_wr       <= w_wr_next;
            r_rd       <= w_rd_next;
            r_phase    <= w_phase_next;
            r_pair     <= w_pair_next;
            r_cyc      <= w_cyc_next;
            r_acc      <= w_acc_next;
            r_swap_cnt <= w_swap_cnt_next;
        end
    end

    // Output flops track the next state so they line up with the state register.
    always_ff @(posedge Clk or negedge nRst) begin
        if (!nRst) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_next == LOAD);
            r_out_valid <= (w_state_next == DRAIN);
            r_busy      <= (w_state_next == SORT);
            if (w_state_next == DRAIN) begin
                r_out_data <= w_buf_next[w_rd_next];
                r_out_last <= (w_rd_next == LAST_IDX);
            end else begin
                r_out_data <= '0;
                r_out_last <= 1'b0;
            end
        end
    end

    assign InReady   = r_in_ready;
    assign OutValid  = r_out_valid;
    assign OutLast   = r_out_last;
    assign OutData   = r_out_data;
    assign Busy      = r_busy;
    assign SwapCount = r_swap_cnt;

endmodule

// File: tb/tb_minmax_sort_engine.sv
// Self-checking bench for minmax_sort_engine at DEPTH=4, DATA_WIDTH=8.
module tb_minmax_sort_engine;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int SCW = 3;
    localparam int S   = 6;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic                 in_valid  = 1'b0;
    logic                 out_ready = 1'b0;
    logic                 abort     = 1'b0;
    logic signed [W-1:0]  in_data   = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_last;
    logic                 busy;
    logic signed [W-1:0]  out_data;
    logic [SCW-1:0]       swap_count;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        int w0; int w1; int w2; int w3;
        int e0; int e1; int e2; int e3;
        int sw;
    } vec_t;

    minmax_sort_engine #(
        .DATA_WIDTH (W),
        .DEPTH      (D)
    ) dut (
        .Clk       (clk),
        .nRst      (rst_n),
        .InValid   (in_valid),
        .InReady   (in_ready),
        .InData    (in_data),
        .OutValid  (out_valid),
        .OutReady  (out_ready),
        .OutData   (out_data),
        .OutLast   (out_last),
        .Abort     (abort),
        .Busy      (busy),
        .SwapCount (swap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: descending order by insertion, exchange count = number of inversions.
    task automatic model(input int w[D], output int e[D], output int sw);
        int q[$];
        sw = 0;
        for (int i = 0; i < D; i++)
            for (int j = i + 1; j < D; j++)
                if (w[i] < w[j]) sw++;
        for (int i = 0; i < D; i++) begin
            int pos = 0;
            while (pos < q.size() && q[pos] >= w[i]) pos++;
            q.insert(pos, w[i]);
        end
        for (int i = 0; i < D; i++) e[i] = q[i];
    endtask

    task automatic load_words(input int w[D], input bit gaps, input bit hold);
        for (int k = 0; k < D; k++) begin
            if (gaps) begin
                int g = $urandom_range(0, 2);
                repeat (g) begin
                    in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_data  = W'(w[k]);
            chk("in_ready_load", int'(in_ready), 1);
            @(negedge clk);
        end
        in_valid = hold;
        in_data  = 8'sh55;
    endtask

    task automatic wait_sort(input int exp_sw, input bit hold);
        int busy_cnt = 0;
        int waited   = 0;
        while (!out_valid && waited < 40) begin
            if (busy) busy_cnt++;
            if (hold) chk("in_ready_sort", int'(in_ready), 0);
            waited++;
            @(negedge clk);
        end
        chk("ovalid_latency", waited, S);
        chk("busy_cycles", busy_cnt, S);
        chk("swap_count", int'(swap_count), exp_sw);
    endtask

    task automatic drain(input int e[D], input int exp_sw, input int stall, input bit hold);
        int idx   = 0;
        int left  = stall;
        int guard = 0;
        while (idx < D && guard < 40) begin
            guard++;
            chk("ovalid_drain", int'(out_valid), 1);
            if (out_valid) begin
                chk("out_data", int'(out_data), e[idx]);
                chk("out_last", int'(out_last), (idx == D - 1) ? 1 : 0);
                if (hold) chk("in_ready_drain", int'(in_ready), 0);
                if (idx == 2 && left > 0) begin
                    out_ready = 1'b0;
                    left--;
                end else begin
                    out_ready = 1'b1;
                    if (idx == D - 1) in_valid = 1'b0;
                    idx++;
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("drain_count", idx, D);
        chk("in_ready_after", int'(in_ready), 1);
        chk("ovalid_after", int'(out_valid), 0);
        chk("swap_hold", int'(swap_count), exp_sw);
    endtask

    task automatic run_batch(input int w[D], input int e[D], input int sw,
                             input bit gaps, input int stall, input bit hold);
        load_words(w, gaps, hold);
        wait_sort(sw, hold);
        drain(e, sw, stall, hold);
    endtask

    task automatic run_model_batch(input int w[D], input bit gaps, input int stall, input bit hold);
        int e[D];
        int sw;
        model(w, e, sw);
        run_batch(w, e, sw, gaps, stall, hold);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"},  int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_out_last"},  int'(out_last), 0);
        chk({tag, "_out_data"},  int'(out_data), 0);
        chk({tag, "_busy"},      int'(busy), 0);
        chk({tag, "_swap"},      int'(swap_count), 0);
    endtask

    initial begin
        vec_t tbl[5];
        int   w[D];
        int   e[D];
        int   b5[D];

        tbl[0] = '{3, -1, 7, 0,          7, 3, 0, -1,           3};
        tbl[1] = '{1, 2, 3, 4,           4, 3, 2, 1,            6};
        tbl[2] = '{4, 3, 2, 1,           4, 3, 2, 1,            0};
        tbl[3] = '{-128, 127, -128, 127, 127, 127, -128, -128,  3};
        tbl[4] = '{5, 9, -2, 9,          9, 9, 5, -2,           3};
        b5 = '{5, 9, -2, 9};

        // Reset state
        repeat (2) @(negedge clk);
        check_idle("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_rst");

        // Table-driven directed batches
        for (int t = 0; t < 5; t++) begin
            w = '{tbl[t].w0, tbl[t].w1, tbl[t].w2, tbl[t].w3};
            e = '{tbl[t].e0, tbl[t].e1, tbl[t].e2, tbl[t].e3};
            run_batch(w, e, tbl[t].sw, 1'b0, 0, 1'b0);
        end

        // Gapped load with a 3-cycle output stall after the second word
        w = '{10, -20, 30, -40};
        e = '{30, 10, -20, -40};
        run_batch(w, e, 2, 1'b1, 3, 1'b0);

        // InValid held through SORT/DRAIN: nothing extra stored, next batch clean
        w = '{2, -3, 2, 0};
        e = '{2, 2, 0, -3};
        run_batch(w, e, 2, 1'b0, 0, 1'b1);
        w = '{tbl[0].w0, tbl[0].w1, tbl[0].w2, tbl[0].w3};
        e = '{tbl[0].e0, tbl[0].e1, tbl[0].e2, tbl[0].e3};
        run_batch(w, e, 3, 1'b0, 0, 1'b0);

        // Abort in SORT cycle 3
        w = '{1, 2, 3, 4};
        load_words(w, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        chk("swap_stable_in_sort", int'(swap_count), 3);
        chk("busy_before_abort", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort_sort");

        // Abort during LOAD with a same-cycle word: partial batch discarded
        in_valid = 1'b1; in_data = 8'sd100; @(negedge clk);
        in_valid = 1'b1; in_data = 8'sd101; @(negedge clk);
        in_valid = 1'b1; in_data = 8'sd120; abort = 1'b1; @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        check_idle("abort_load");
        e = '{9, 9, 5, -2};
        run_batch(b5, e, 3, 1'b0, 0, 1'b0);

        // nRst low mid-DRAIN
        w = '{3, -1, 7, 0};
        load_words(w, 1'b0, 1'b0);
        wait_sort(3, 1'b0);
        chk("first_word", int'(out_data), 7);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("second_word", int'(out_data), 3);
        rst_n = 1'b0;
        #1;
        check_idle("rst_drain");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("rst_drain_rel");
        run_batch(b5, e, 3, 1'b0, 0, 1'b0);

        // Randomized batches against the reference model
        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < D; k++) begin
                if (r % 3 == 0) w[k] = $urandom_range(0, 4) - 2;
                else            w[k] = $urandom_range(0, 255) - 128;
            end
            run_model_batch(w, ($urandom_range(0, 1) == 1), $urandom_range(0, 3),
                            ($urandom_range(0, 3) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/minmax_sort_engine.md
# minmax_sort_engine

- Batch sorter: accepts DEPTH signed words on a valid/ready input stream, then sorts them in place by odd-even transposition.
- One time-shared compare-exchange unit performs the sort, one pair per clock.
- Returns the words in descending order on a valid/ready output stream.
- Sits behind the min/max compare datapath as its sequencer; used wherever a small ranked set is needed (median/peak selection, top-k).

## Interface
- DATA_WIDTH, 8, word width; two's-complement signed.
- DEPTH, 8, words per batch; legal range ≥ 2.
- Clk  in  1  rising-edge clock.
- nRst  in  1  reset; asynchronous assert, active-low.
- InValid  in  1  input word valid.
- InReady  out  1  engine accepts a word this cycle.
- InData  in  DATA_WIDTH  signed input word.
- OutValid  out  1  output word valid.
- OutReady  in  1  downstream accepts the word.
- OutData  out  DATA_WIDTH  sorted word, largest first.
- OutLast  out  1  marks the final word of the batch; qualified by OutValid.
- Abort  in  1  synchronous batch discard.
- Busy  out  1  high in SORT.
- SwapCount  out  SCW  exchanges performed in the last completed sort.
  - SCW = clog2(DEPTH*(DEPTH-1)/2 + 1).

## Operation
- States: LOAD → SORT → DRAIN → LOAD.
- LOAD
  - InReady=1.
  - Each handshake (InValid&InReady) writes InData to buf[wr], then wr++.
  - The handshake that writes index DEPTH-1 moves to SORT; it also clears wr, the phase/pair counters and the swap accumulator.
- SORT
  - Runs DEPTH phases, p = 0..DEPTH-1.
  - Even p: compares pairs (0,1), (2,3), …; E = floor(DEPTH/2) cycles.
  - Odd p: compares pairs (1,2), (3,4), …; O = floor((DEPTH-1)/2) cycles.
  - Each cycle one pair (i, i+1) goes through the compare-exchange.
  - If buf[i] < buf[i+1] (signed, strict): swap, and the accumulator increments.
  - Equal values are never swapped.
  - Total S = ceil(DEPTH/2)*E + floor(DEPTH/2)*O cycles, fixed and data-independent. DEPTH=4 → 6; DEPTH=8 → 28.
  - The final exchange edge loads SwapCount from the accumulator (including that edge's swap) and enters DRAIN.
- DRAIN
  - OutValid=1; OutData=buf[rd]; OutLast=(rd==DEPTH-1).
  - Each OutValid&OutReady advances rd.
  - The handshake on rd=DEPTH-1 clears rd and returns to LOAD.
  - While OutReady=0, OutData/OutLast are held stable.
- InReady=0 outside LOAD; input in SORT/DRAIN is ignored, not queued.
- Abort (any state): next edge → LOAD with wr=rd=0 and SwapCount=0.
  - Abort overrides any same-cycle handshake; that word is neither stored nor counted.
- nRst asserted: immediately LOAD with buf, counters and SwapCount cleared. Applies mid-SORT or mid-DRAIN with no partial output.

## Timing
- Reset values: InReady=1, OutValid=0, OutLast=0, OutData=0, Busy=0, SwapCount=0.
- OutValid first rises in the cycle starting S edges after the edge that accepted word DEPTH-1.
- Busy is high for exactly S cycles.
- Drain: one word per cycle at OutReady=1.
- InReady rises the cycle after the OutLast handshake.
- Minimum batch period: DEPTH + S + DEPTH cycles.
- SwapCount is stable from DRAIN entry until the next SORT completes, an Abort, or reset.

## Structure
- Shared package minmax_pkg:
  - state enum {LOAD, SORT, DRAIN};
  - SCW and the S-cycle function as shared constants/functions.
- Sub-module minmax_cx:
  - combinational signed compare-exchange;
  - inputs A, B; outputs Hi, Lo, Swapped (Swapped = A<B).
- Engine holds buf as a register array with counters wr, rd, phase, pair.
- Two-index read/write per cycle → registers, not RAM.

## Test plan
- DEPTH=4, W=8. Load 3, -1, 7, 0 with no gaps → Busy high 6 cycles; output 7, 3, 0, -1; OutLast on -1; SwapCount=3.
- Load 1, 2, 3, 4 → output 4, 3, 2, 1, SwapCount=6. Then load 4, 3, 2, 1 → same output, SwapCount=0.
- Load -128, 127, -128, 127 → output 127, 127, -128, -128; SwapCount=3; equal values never swapped.
- Random InValid gaps on load; OutReady held low 3 cycles after the second word → data/OutLast stable while stalled; all 4 words delivered once, in order.
- Abort in SORT cycle 3, and separately nRst low mid-DRAIN → LOAD next cycle; OutValid=0; SwapCount=0. Next batch 5, 9, -2, 9 → output 9, 9, 5, -2.
- InValid=1 throughout SORT/DRAIN → InReady=0; no extra word written; the next batch starts cleanly after OutLast.
